// File: rtl/matrixops_pkg.sv
// rtl/matrixops_pkg.sv - state encoding, default sizes and beat counter width for the matrixops feed arbiter
package matrixops_pkg;

  localparam int DEF_ELEMS    = 4;
  localparam int DEF_RES_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PAR,
    ST_GAP,
    ST_CAPT,
    ST_DONE
  } state_e;

  // One counter serves both the DATA and CAPT phases, so size it for the longer one.
  function automatic int beat_cnt_w(input int elems, input int res_bits);
    int m;
    m = (elems > res_bits) ? elems : res_bits;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int DEF_CNT_W = beat_cnt_w(DEF_ELEMS, DEF_RES_BITS);

endpackage

// File: rtl/mxa_rr_arbiter.sv
// rtl/mxa_rr_arbiter.sv - 2-way round-robin pick with a last-served pointer
module mxa_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served_id,
  output logic winner
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (update) last_d = served_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_q;
    else if (req1)    winner = 1'b1;
  end

endmodule

// File: rtl/matrixops_feed_arbiter.sv
// rtl/matrixops_feed_arbiter.sv - shares one matrixops serial port between two requesters
// Optional parity beat after the operand beats: MATRIXOPS_FEED_PARITY_EN
module matrixops_feed_arbiter
  import matrixops_pkg::*;
#(
  parameter int ELEMS    = DEF_ELEMS,
  parameter int RES_BITS = DEF_RES_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [1:0]           op0,
  input  logic [2*ELEMS-1:0]   a0,
  input  logic [2*ELEMS-1:0]   b0,
  input  logic                 req1,
  input  logic [1:0]           op1,
  input  logic [2*ELEMS-1:0]   a1,
  input  logic [2*ELEMS-1:0]   b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [RES_BITS-1:0]  result,
  output logic                 enter,
  output logic [1:0]           X,
  output logic [1:0]           Y,
  input  logic                 Z
);

  localparam int CNT_W = beat_cnt_w(ELEMS, RES_BITS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [1:0]            op_q, op_d;
  logic [2*ELEMS-1:0]    a_q, a_d, b_q, b_d;
  logic [RES_BITS-1:0]   shift_q, shift_d, result_q, result_d;
  logic                  enter_q, enter_d;
  logic [1:0]            x_q, x_d, y_q, y_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  winner, rr_update;

`ifdef MATRIXOPS_FEED_PARITY_EN
  function automatic logic [1:0] xor_elems(input logic [2*ELEMS-1:0] v);
    logic [1:0] acc;
    acc = '0;
    for (int k = 0; k < ELEMS; k++) acc = acc ^ v[2*k +: 2];
    return acc;
  endfunction
`endif

  mxa_rr_arbiter u_rr (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .update    (rr_update),
    .served_id (owner_q),
    .winner    (winner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    shift_d   = shift_q;
    result_d  = result_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rr_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          op_d    = winner ? op1 : op0;
          a_d     = winner ? a1  : a0;
          b_d     = winner ? b1  : b0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(ELEMS - 1)) begin
          cnt_d = '0;
`ifdef MATRIXOPS_FEED_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_GAP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAR: state_d = ST_GAP;
      ST_GAP: begin
        cnt_d   = '0;
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        shift_d = {Z, shift_q[RES_BITS-1:1]};
        if (cnt_q == CNT_W'(RES_BITS - 1)) state_d = ST_DONE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        result_d  = shift_q;
        done0_d   = ~owner_q;
        done1_d   = owner_q;
        rr_update = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port outputs are registered, so they are derived from the state being entered.
    enter_d = 1'b0;
    x_d     = 2'b00;
    y_d     = 2'b00;
    case (state_d)
      ST_HDR: begin
        enter_d = 1'b1;
        x_d     = op_d;
      end
      ST_DATA: begin
        enter_d = 1'b1;
        for (int k = 0; k < ELEMS; k++) begin
          if (cnt_d == CNT_W'(k)) begin
            x_d = a_d[2*k +: 2];
            y_d = b_d[2*k +: 2];
          end
        end
      end
`ifdef MATRIXOPS_FEED_PARITY_EN
      ST_PAR: begin
        enter_d = 1'b1;
        x_d     = xor_elems(a_d);
        y_d     = xor_elems(b_d);
      end
`endif
      default: ;
    endcase

    gnt0_d = ((state_d != ST_IDLE) && !owner_d) || done0_d;
    gnt1_d = ((state_d != ST_IDLE) &&  owner_d) || done1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      result_q <= '0;
      enter_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      enter_q  <= enter_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign enter  = enter_q;
  assign X      = x_q;
  assign Y      = y_q;

endmodule

// File: tb/tb_matrixops_feed_arbiter.sv
// tb/tb_matrixops_feed_arbiter.sv - directed self-checking bench for matrixops_feed_arbiter
module tb_matrixops_feed_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] result;
  logic       enter;
  logic [1:0] X, Y;
  logic       Z;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MATRIXOPS_FEED_PARITY_EN
  localparam int DONE_CYC = 16;
  localparam int NBEATS   = 7;
`else
  localparam int DONE_CYC = 15;
  localparam int NBEATS   = 6;
`endif
  localparam int CAPT_START = DONE_CYC - 9;

  always #5 clk = ~clk;

  matrixops_feed_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .op0    (op0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .op1    (op1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .enter  (enter),
    .X      (X),
    .Y      (Y),
    .Z      (Z)
  );

  task automatic test_reset();
    logic [17:0] outs;
    bit seen;
    @(negedge clk);
    outs = {gnt0, gnt1, done0, done1, enter, X, Y, result};
    n_cmp++;
    if (outs !== 18'h0) begin n_bad++; $display("FAIL reset_init got %h want 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd2; a0 = 8'hE4; b0 = 8'h1B;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (enter !== 1'b1) begin n_bad++; $display("FAIL reset_pre_data enter got %b want 1", enter); end
    rst = 1'b1;
    req1 = 1'b1;
    #1;
    outs = {gnt0, gnt1, done0, done1, enter, X, Y, result};
    n_cmp++;
    if (outs !== 18'h0) begin n_bad++; $display("FAIL reset_async got %h want 0", outs); end
    @(negedge clk);
    outs = {gnt0, gnt1, done0, done1, enter, X, Y, result};
    n_cmp++;
    if (outs !== 18'h0) begin n_bad++; $display("FAIL reset_held got %h want 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, enter, X} !== 5'b10110) begin
      n_bad++; $display("FAIL reset_first_grant got %b want 10110", {gnt0, gnt1, enter, X});
    end
    req0 = 1'b0; req1 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL reset_frame_done got %b want 1", seen); end
  endtask

  task automatic test_single_frame();
    logic [4:0] exp_b [NBEATS];
    logic [4:0] want;
    logic [7:0] zv;
    zv = 8'hA5;
`ifdef MATRIXOPS_FEED_PARITY_EN
    exp_b = '{5'b1_10_00, 5'b1_00_11, 5'b1_01_10, 5'b1_10_01, 5'b1_11_00, 5'b1_00_00, 5'b0_00_00};
`else
    exp_b = '{5'b1_10_00, 5'b1_00_11, 5'b1_01_10, 5'b1_10_01, 5'b1_11_00, 5'b0_00_00};
`endif
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd2; a0 = 8'hE4; b0 = 8'h1B;
    @(posedge clk);
    for (int c = 0; c <= DONE_CYC; c++) begin
      @(negedge clk);
      if (c == 0) req0 = 1'b0;
      if (c >= CAPT_START && c < CAPT_START + 8) Z = zv[c - CAPT_START];
      else Z = 1'b0;
      want = (c < NBEATS) ? exp_b[c] : 5'b0;
      n_cmp++;
      if ({enter, X, Y} !== want) begin
        n_bad++; $display("FAIL frame_beat c=%0d got %b want %b", c, {enter, X, Y}, want);
      end
      n_cmp++;
      if (done0 !== (c == DONE_CYC)) begin
        n_bad++; $display("FAIL frame_done0 c=%0d got %b want %b", c, done0, (c == DONE_CYC));
      end
      n_cmp++;
      if ({gnt0, gnt1, done1} !== 3'b100) begin
        n_bad++; $display("FAIL frame_gnt c=%0d got %b want 100", c, {gnt0, gnt1, done1});
      end
    end
    n_cmp++;
    if (result !== 8'hA5) begin n_bad++; $display("FAIL frame_result got %h want a5", result); end
  endtask

  task automatic test_result_hold();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0, done0, result} !== {2'b00, 8'hA5}) begin
        n_bad++; $display("FAIL hold c=%0d got %b want 0010100101", c, {gnt0, done0, result});
      end
    end
  endtask

  task automatic test_contention();
    int ndone, ngnt, overlap;
    int dseq [3];
    int gseq [3];
    logic pg0, pg1;
    ndone = 0; ngnt = 0; overlap = 0; pg0 = 1'b0; pg1 = 1'b0;
    dseq = '{9, 9, 9};
    gseq = '{9, 9, 9};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op0 = 2'd1; a0 = 8'h00; b0 = 8'h00;
    op1 = 2'd2; a1 = 8'hFF; b1 = 8'hFF;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 80 && ndone < 3; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) overlap++;
      if (gnt0 && !pg0 && ngnt < 3) begin gseq[ngnt] = 0; ngnt++; end
      if (gnt1 && !pg1 && ngnt < 3) begin gseq[ngnt] = 1; ngnt++; end
      pg0 = gnt0; pg1 = gnt1;
      if (done0 && ndone < 3) begin dseq[ndone] = 0; ndone++; end
      if (done1 && ndone < 3) begin dseq[ndone] = 1; ndone++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if (ndone !== 3) begin n_bad++; $display("FAIL cont_ndone got %0d want 3", ndone); end
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL cont_overlap got %0d want 0", overlap); end
    n_cmp++;
    if (gseq[0] !== 0 || gseq[1] !== 1 || gseq[2] !== 0) begin
      n_bad++; $display("FAIL cont_gnt_order got %0d,%0d,%0d want 0,1,0", gseq[0], gseq[1], gseq[2]);
    end
    n_cmp++;
    if (dseq[0] !== 0 || dseq[1] !== 1 || dseq[2] !== 0) begin
      n_bad++; $display("FAIL cont_done_order got %0d,%0d,%0d want 0,1,0", dseq[0], dseq[1], dseq[2]);
    end
  endtask

  task automatic test_robustness();
    logic [4:0] exp_b [NBEATS];
    logic [4:0] want;
`ifdef MATRIXOPS_FEED_PARITY_EN
    exp_b = '{5'b1_11_00, 5'b1_01_10, 5'b1_10_01, 5'b1_11_00, 5'b1_00_11, 5'b1_00_00, 5'b0_00_00};
`else
    exp_b = '{5'b1_11_00, 5'b1_01_10, 5'b1_10_01, 5'b1_11_00, 5'b1_00_11, 5'b0_00_00};
`endif
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd3; a0 = 8'h39; b0 = 8'hC6; Z = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= DONE_CYC; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req0 = 1'b0; op0 = 2'd0; a0 = 8'hFF; b0 = 8'h00;
      end
      want = (c < NBEATS) ? exp_b[c] : 5'b0;
      n_cmp++;
      if ({enter, X, Y} !== want) begin
        n_bad++; $display("FAIL robust_beat c=%0d got %b want %b", c, {enter, X, Y}, want);
      end
      n_cmp++;
      if (done0 !== (c == DONE_CYC)) begin
        n_bad++; $display("FAIL robust_done0 c=%0d got %b want %b", c, done0, (c == DONE_CYC));
      end
    end
    n_cmp++;
    if (result !== 8'hFF) begin n_bad++; $display("FAIL robust_result got %h want ff", result); end
    Z = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    Z = 1'b0;
    test_reset();
    test_single_frame();
    test_result_hold();
    test_contention();
    test_robustness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
